alu_arbiter: RTL

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : alu_arbiter
//  Purpose  : Round-robin arbiter sharing one combinational ALU between two
//             requesters, one operation in flight, with held responses.
//  Revision : 1.0  initial release
// ============================================================================
module alu_arbiter #(
  parameter int DATA_W  = 8,
  parameter int NUM_OPS = 11
) (
  input  logic              clk,
  input  logic              rst,
  // requester 0
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [3:0]        req0_sel,
  // requester 1
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [3:0]        req1_sel,
  // shared ALU
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_select,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_carry,
  input  logic              alu_overflow,
  input  logic              alu_zero,
  input  logic              alu_negative,
  // responses
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_result,
  output logic [4:0]        rsp0_flags,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_result,
  output logic [4:0]        rsp1_flags
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ISSUE   = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;
  localparam logic [1:0] RESP    = 2'd3;

  localparam logic [4:0] c_err_flags = 5'b10000;

  logic [1:0]        r_state;
  logic              r_last;     // id of the requester granted most recently
  logic              r_owner;
  logic              r_illegal;

  logic              w_grant;
  logic              w_hs;
  logic [3:0]        w_hs_sel;
  logic              w_sel_illegal;
  logic              w_consume;
  logic [DATA_W-1:0] w_cap_result;
  logic [4:0]        w_cap_flags;

  // With both valid the requester not served last wins; r_last resets to 1 so req0 leads.
  assign w_grant    = (req0_valid && req1_valid) ? ~r_last : req1_valid;
  assign req0_ready = !rst && (r_state == IDLE) && req0_valid && !w_grant;
  assign req1_ready = !rst && (r_state == IDLE) && req1_valid &&  w_grant;
  assign w_hs       = req0_ready || req1_ready;

  assign w_hs_sel      = w_grant ? req1_sel : req0_sel;
  assign w_sel_illegal = (32'(w_hs_sel) >= 32'(NUM_OPS));
  assign w_consume     = r_owner ? rsp1_ready : rsp0_ready;

  assign w_cap_result = r_illegal ? '0 : alu_result;
  assign w_cap_flags  = r_illegal ? c_err_flags
                                  : {1'b0, alu_negative, alu_zero, alu_overflow, alu_carry};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_last      <= 1'b1;
      r_owner     <= 1'b0;
      r_illegal   <= 1'b0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_select  <= '0;
      rsp0_valid  <= 1'b0;
      rsp1_valid  <= 1'b0;
      rsp0_result <= '0;
      rsp1_result <= '0;
      rsp0_flags  <= '0;
      rsp1_flags  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_hs) begin
            r_owner   <= w_grant;
            r_last    <= w_grant;
            r_illegal <= w_sel_illegal;
            // Illegal selects never reach the ALU, so its operands keep their last value.
            if (w_sel_illegal) begin
              r_state <= CAPTURE;
            end else begin
              alu_a      <= w_grant ? req1_a : req0_a;
              alu_b      <= w_grant ? req1_b : req0_b;
              alu_select <= w_hs_sel;
              r_state    <= ISSUE;
            end
          end
        end
        ISSUE: begin
          r_state <= CAPTURE;
        end
        CAPTURE: begin
          if (r_owner) begin
            rsp1_result <= w_cap_result;
            rsp1_flags  <= w_cap_flags;
            rsp1_valid  <= 1'b1;
          end else begin
            rsp0_result <= w_cap_result;
            rsp0_flags  <= w_cap_flags;
            rsp0_valid  <= 1'b1;
          end
          r_state <= RESP;
        end
        RESP: begin
          if (w_consume) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            r_state    <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
